// File: rtl/instr_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_access
//  Description : Memory-access pipeline stage that sits after execute.
//                ALU-pass and bubble ops retire one cycle after acceptance.
//                Loads and stores issue a req/ack bus transaction. The stage
//                stalls upstream (in_ready=0) until the transaction completes
//                with an ack or is aborted by the timeout counter.
//  Ports       : clk, reset (sync, active-high), flush
//                in_valid/update_in/MaInData/in_ready  - execute side
//                mem_req/mem_we/mem_addr/mem_wdata/
//                mem_rdata/mem_ack                      - data-memory bus
//                wb_valid/wb_en/wb_dest/wb_data         - write-back bundle
//                mem_err                                - timeout pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_access #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              update_in,
    input  logic [2*DATA_W+4:0] MaInData,
    output logic              in_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [2:0]        wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_WAIT    = 1'b1;

    localparam logic [1:0] c_OP_ALU    = 2'b00;
    localparam logic [1:0] c_OP_LOAD   = 2'b01;
    localparam logic [1:0] c_OP_STORE  = 2'b10;
    localparam logic [1:0] c_OP_BUBBLE = 2'b11;

    // Counter is one bit wider than the largest TIMEOUT so the incremented
    // value never wraps before the compare.
    localparam logic [8:0] c_TIMEOUT = 9'(TIMEOUT);

    logic [0:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_kill;
    logic [2:0]        r_ld_dest;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wb_valid;
    logic              r_wb_en;
    logic [2:0]        r_wb_dest;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_mem_err;

    logic [1:0]        w_op;
    logic [2:0]        w_dest;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_opa;
    logic              w_accept;
    logic              w_kill;
    logic [8:0]        w_cnt_next;

    assign w_op       = MaInData[1:0];
    assign w_dest     = MaInData[4:2];
    assign w_result   = MaInData[DATA_W+4:5];
    assign w_opa      = MaInData[2*DATA_W+4:DATA_W+5];

    assign in_ready   = (r_state == c_IDLE);
    assign w_accept   = in_valid && in_ready && !flush;
    // A flush arriving on the completing edge squashes just like an earlier one.
    assign w_kill     = r_kill || flush;
    assign w_cnt_next = {1'b0, r_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_ld_dest   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_data   <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            // Pulsed outputs default low; dest/data hold their last value.
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_mem_err  <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            c_OP_ALU: begin
                                r_wb_valid <= 1'b1;
                                r_wb_en    <= update_in;
                                r_wb_dest  <= w_dest;
                                r_wb_data  <= w_result;
                            end
                            c_OP_BUBBLE: begin
                                r_wb_valid <= 1'b1;
                            end
                            c_OP_LOAD, c_OP_STORE: begin
                                r_mem_req   <= 1'b1;
                                r_mem_we    <= (w_op == c_OP_STORE);
                                r_mem_addr  <= w_result;
                                r_mem_wdata <= w_opa;
                                r_ld_dest   <= w_dest;
                                r_cnt       <= '0;
                                r_kill      <= 1'b0;
                                r_state     <= c_WAIT;
                            end
                            default: ;
                        endcase
                    end
                end

                c_WAIT: begin
                    if (mem_ack) begin
                        // Ack has priority over a timeout reached on the same edge.
                        r_mem_req  <= 1'b0;
                        r_state    <= c_IDLE;
                        r_kill     <= 1'b0;
                        r_wb_valid <= !w_kill;
                        if (!r_mem_we && !w_kill) begin
                            r_wb_en   <= 1'b1;
                            r_wb_dest <= r_ld_dest;
                            r_wb_data <= mem_rdata;
                        end
                    end else if (w_cnt_next == c_TIMEOUT) begin
                        r_mem_req  <= 1'b0;
                        r_state    <= c_IDLE;
                        r_kill     <= 1'b0;
                        r_wb_valid <= !w_kill;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next[7:0];
                        if (flush) begin
                            r_kill <= 1'b1;
                        end
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign wb_valid  = r_wb_valid;
    assign wb_en     = r_wb_en;
    assign wb_dest   = r_wb_dest;
    assign wb_data   = r_wb_data;
    assign mem_err   = r_mem_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_access
//  Description : Scoreboard bench for instr_mem_access. Expected retirement
//                events are queued when an instruction is driven and
//                compared when wb_valid or mem_err appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_access;

    localparam int c_DW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              update_in = 1'b0;
    logic [36:0]       MaInData = '0;
    logic              in_ready;
    logic              mem_req;
    logic              mem_we;
    logic [c_DW-1:0]   mem_addr;
    logic [c_DW-1:0]   mem_wdata;
    logic [c_DW-1:0]   mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              wb_valid;
    logic              wb_en;
    logic [2:0]        wb_dest;
    logic [c_DW-1:0]   wb_data;
    logic              mem_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic            v;
        logic            en;
        logic            err;
        logic [2:0]      dest;
        logic [c_DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    instr_mem_access #(.DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .update_in(update_in), .MaInData(MaInData), .in_ready(in_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_dest(wb_dest),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every retirement or error pulse must match the head.
    always @(negedge clk) begin
        if (!reset && (wb_valid || mem_err)) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_retire: wb_valid=%0b wb_en=%0b mem_err=%0b with empty scoreboard",
                         wb_valid, wb_en, mem_err);
            end else begin
                e = sb.pop_front();
                if ({wb_valid, wb_en, mem_err} !== {e.v, e.en, e.err}) begin
                    failures++;
                    $display("FAIL retire_flags: got v/en/err=%b%b%b expected %b%b%b",
                             wb_valid, wb_en, mem_err, e.v, e.en, e.err);
                end
                if (e.en) begin
                    checks++;
                    if ({wb_dest, wb_data} !== {e.dest, e.data}) begin
                        failures++;
                        $display("FAIL retire_data: got dest=%0d data=%h expected dest=%0d data=%h",
                                 wb_dest, wb_data, e.dest, e.data);
                    end
                end
            end
        end
    end

    // Drive one instruction for the next edge (caller advances the clock).
    task automatic put(input logic [1:0] op, input logic upd, input logic [15:0] opa,
                       input logic [15:0] res, input logic [2:0] dest);
        in_valid  = 1'b1;
        update_in = upd;
        MaInData  = {opa, res, dest, op};
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        update_in = 1'b0;
        MaInData  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, wb_valid, wb_en, mem_err, wb_data, wb_dest, mem_addr} !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: req=%b wbv=%b en=%b err=%b data=%h rdy=%b required all 0, rdy=1",
                     mem_req, wb_valid, wb_en, mem_err, wb_data, in_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        put(2'b00, 1'b1, 16'h5555, 16'h0003, 3'd6);
        sb.push_back('{v:1'b1, en:1'b1, err:1'b0, dest:3'd6, data:16'h0003});
        @(negedge clk);
        idle_in();
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_ready: in_ready=%b mem_req=%b required 1/0", in_ready, mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        put(2'b00, 1'b0, 16'h0, 16'hA5A5, 3'd2);
        sb.push_back('{v:1'b1, en:1'b0, err:1'b0, dest:3'd0, data:16'h0});
        @(negedge clk);
        put(2'b11, 1'b1, 16'h0, 16'h7777, 3'd5);
        sb.push_back('{v:1'b1, en:1'b0, err:1'b0, dest:3'd0, data:16'h0});
        @(negedge clk);
        put(2'b00, 1'b1, 16'h0, 16'h1234, 3'd1);
        sb.push_back('{v:1'b1, en:1'b1, err:1'b0, dest:3'd1, data:16'h1234});
        @(negedge clk);
        idle_in();
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready: in_ready=%b mem_req=%b required 1/0", in_ready, mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        put(2'b01, 1'b0, 16'h9999, 16'h0040, 3'd3);
        sb.push_back('{v:1'b1, en:1'b1, err:1'b0, dest:3'd3, data:16'hBEEF});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            idle_in();
            checks++;
            if ({mem_req, mem_we, in_ready} !== 3'b100 || mem_addr !== 16'h0040) begin
                failures++;
                $display("FAIL load_wait%0d: req/we/rdy=%b%b%b addr=%h required 100 addr=0040",
                         i, mem_req, mem_we, in_ready, mem_addr);
            end
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hBEEF;
            end
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_done: mem_req=%b in_ready=%b required 0/1", mem_req, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        put(2'b10, 1'b1, 16'h1234, 16'h0010, 3'd4);
        sb.push_back('{v:1'b1, en:1'b0, err:1'b0, dest:3'd0, data:16'h0});
        @(negedge clk);
        idle_in();
        checks++;
        if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0010) begin
            failures++;
            $display("FAIL store_bus: req/we=%b%b wdata=%h addr=%h required 11 1234 0010",
                     mem_req, mem_we, mem_wdata, mem_addr);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL store_done: mem_req=%b required 0", mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n = 0;
        put(2'b01, 1'b1, 16'h0, 16'h0080, 3'd7);
        sb.push_back('{v:1'b1, en:1'b0, err:1'b1, dest:3'd0, data:16'h0});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            idle_in();
            if (mem_req) n++;
            else break;
        end
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL timeout_len: mem_req high %0d cycles required 15", n);
        end
        put(2'b00, 1'b1, 16'h0, 16'h00C3, 3'd2);
        sb.push_back('{v:1'b1, en:1'b1, err:1'b0, dest:3'd2, data:16'h00C3});
        @(negedge clk);
        idle_in();
        @(negedge clk);
    endtask

    task automatic test_ack_at_limit();
        put(2'b01, 1'b0, 16'h0, 16'h0100, 3'd5);
        sb.push_back('{v:1'b1, en:1'b1, err:1'b0, dest:3'd5, data:16'hC0DE});
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            idle_in();
            if (i == 15) begin
                checks++;
                if (mem_req !== 1'b1) begin
                    failures++;
                    $display("FAIL limit_req: mem_req=%b required 1 in cycle 15", mem_req);
                end
                mem_ack   = 1'b1;
                mem_rdata = 16'hC0DE;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        // Flush during WAIT: handshake finishes, no retirement.
        put(2'b01, 1'b1, 16'h0, 16'h0200, 3'd1);
        @(negedge clk);
        idle_in();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold: mem_req=%b in_ready=%b required 1/0", mem_req, in_ready);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clk);
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_done: mem_req=%b wb_valid=%b required 0/0", mem_req, wb_valid);
        end
        // Flush in IDLE with a valid instruction: dropped.
        put(2'b01, 1'b1, 16'h0, 16'h0300, 3'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle: mem_req=%b wb_valid=%b in_ready=%b required 0/0/1",
                     mem_req, wb_valid, in_ready);
        end
        // Flushed load that times out: error pulse only.
        put(2'b01, 1'b1, 16'h0, 16'h0400, 3'd3);
        sb.push_back('{v:1'b0, en:1'b0, err:1'b1, dest:3'd0, data:16'h0});
        @(negedge clk);
        idle_in();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        put(2'b01, 1'b1, 16'h0, 16'h0500, 3'd4);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({mem_req, wb_valid, wb_en, mem_err} !== 4'b0000 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wait: req/wbv/en/err=%b%b%b%b in_ready=%b required 0000/1",
                     mem_req, wb_valid, wb_en, mem_err, in_ready);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ack_ignored: mem_req=%b wb_valid=%b in_ready=%b required 0/0/1",
                     mem_req, wb_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_ack_at_limit();
        test_flush();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
